// File: rtl/pc_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding and parameter defaults.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_WORDS = 128;

endpackage

// File: rtl/pc_fetch_pc_next.sv
// Next-PC selection (redirect target or PC+4) with alignment and range fault check.
module pc_next
    import pc_fetch_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic [31:0] next_pc,
    output logic        fault
);

    always_comb begin
        next_pc = redirect ? target : pc + 32'd4;
        fault   = ({2'b00, next_pc[31:2]} >= IMEM_WORDS)
                  || (redirect && (target[1:0] != 2'b00));
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/ERR FSM and the registered fetch output.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_err
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx, next_pc;
    logic         fault;
    logic         tail, tail_nx;
    logic         load_out, out_valid_nx, fetch_err_nx;
    logic         advance;

    pc_next #(.IMEM_WORDS(IMEM_WORDS)) u_pc_next (
        .pc      (pc),
        .redirect(redirect_valid),
        .target  (redirect_target),
        .next_pc (next_pc),
        .fault   (fault)
    );

    assign imem_addr = pc;
    assign advance   = ~out_valid | out_ready;

    // tail marks that the last in-range word has been loaded but pc could not step
    // past it; the fault is raised only once that word has been consumed.
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        tail_nx      = tail;
        load_out     = 1'b0;
        out_valid_nx = out_valid;
        fetch_err_nx = fetch_err;
        case (state)
            BOOT: begin
                state_nx     = RUN;
                pc_nx        = RESET_PC;
                out_valid_nx = 1'b0;
            end
            RUN: begin
                if (redirect_valid) begin
                    out_valid_nx = 1'b0;
                    tail_nx      = 1'b0;
                    if (fault) begin
                        state_nx     = ERR;
                        fetch_err_nx = 1'b1;
                    end else begin
                        pc_nx = next_pc;
                    end
                end else if (advance) begin
                    if (tail) begin
                        state_nx     = ERR;
                        fetch_err_nx = 1'b1;
                        out_valid_nx = 1'b0;
                    end else begin
                        load_out     = 1'b1;
                        out_valid_nx = 1'b1;
                        if (fault) begin
                            tail_nx = 1'b1;
                        end else begin
                            pc_nx = next_pc;
                        end
                    end
                end
            end
            ERR: begin
                out_valid_nx = 1'b0;
                fetch_err_nx = 1'b1;
            end
            default: begin
                state_nx     = ERR;
                out_valid_nx = 1'b0;
                fetch_err_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            tail      <= 1'b0;
            out_valid <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            tail      <= tail_nx;
            out_valid <= out_valid_nx;
            fetch_err <= fetch_err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_inst     <= '0;
            out_pc       <= '0;
            out_pc_plus4 <= '0;
        end else if (load_out) begin
            out_inst     <= imem_inst;
            out_pc       <= pc;
            out_pc_plus4 <= pc + 32'd4;
        end
    end

endmodule
